scan_chain_loader: RTL and testbench

Host-side driver for the accelerator's configuration scan chain. It accepts one packed layer-configuration vector (H, W, R, S, E, F, C, M, N, U, m, n, e, p, q, r, t) through a valid/ready request and serialises it onto `scan_in` under `scan_en`. While shifting, it captures `scan_out` to return the chain's previous contents. An optional second pass reads the new contents back and compares them with the request.

---
 rtl/scan_chain_loader_pkg.sv | 56 +++++
 rtl/scan_chain_loader_if.sv | 14 +
 rtl/scan_chain.sv | 22 ++
 rtl/scan_chain_loader.sv | 101 ++++++++++
 tb/tb_scan_chain_loader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_chain_loader_pkg.sv
// rtl/scan_chain_loader_pkg.sv - shared widths, config layout and FSM states
// Field order of cfg_t matches the scan chain: t sits at the MSB (scan_out end).
package scan_chain_pkg;

    localparam int H_BITS  = 8;
    localparam int W_BITS  = 8;
    localparam int R_BITS  = 4;
    localparam int S_BITS  = 4;
    localparam int E_BITS  = 6;
    localparam int F_BITS  = 6;
    localparam int C_BITS  = 10;
    localparam int M_BITS  = 10;
    localparam int N_BITS  = 3;
    localparam int U_BITS  = 3;
    localparam int PM_BITS = 8;
    localparam int PN_BITS = 3;
    localparam int PE_BITS = 6;
    localparam int PP_BITS = 5;
    localparam int PQ_BITS = 3;
    localparam int PR_BITS = 2;
    localparam int PT_BITS = 3;

    localparam int CHAIN_LEN = H_BITS + W_BITS + R_BITS + S_BITS + E_BITS + F_BITS
                             + C_BITS + M_BITS + N_BITS + U_BITS + PM_BITS + PN_BITS
                             + PE_BITS + PP_BITS + PQ_BITS + PR_BITS + PT_BITS;

    // Upper-case layer dimensions keep their letter; lower-case mapping
    // parameters (m, n, e, p, q, r, t) carry a p prefix.
    typedef struct packed {
        logic [PT_BITS-1:0] pt;
        logic [PR_BITS-1:0] pr;
        logic [PQ_BITS-1:0] pq;
        logic [PP_BITS-1:0] pp;
        logic [PE_BITS-1:0] pe;
        logic [PN_BITS-1:0] pn;
        logic [PM_BITS-1:0] pm;
        logic [U_BITS-1:0]  u;
        logic [N_BITS-1:0]  n;
        logic [M_BITS-1:0]  m;
        logic [C_BITS-1:0]  c;
        logic [F_BITS-1:0]  f;
        logic [E_BITS-1:0]  e;
        logic [S_BITS-1:0]  s;
        logic [R_BITS-1:0]  r;
        logic [W_BITS-1:0]  w;
        logic [H_BITS-1:0]  h;
    } cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        FIN
    } state_t;

endpackage

// File: rtl/scan_chain_loader_if.sv
// rtl/scan_chain_loader_if.sv - configuration request handshake bundle
interface scan_chain_loader_if
    import scan_chain_pkg::*;
#(
    parameter int N = CHAIN_LEN
);
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_cfg;
    logic         req_verify;

    modport master (output req_valid, output req_cfg, output req_verify, input req_ready);
    modport slave  (input req_valid, input req_cfg, input req_verify, output req_ready);
endinterface

// File: rtl/scan_chain.sv
// rtl/scan_chain.sv - behavioural configuration scan chain (loader's serial load)
// Its reset is kept separate so a loader reset leaves the chain partially shifted.
module scan_chain #(
    parameter int N = 92
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         scan_en,
    input  logic         scan_in,
    output logic         scan_out,
    output logic [N-1:0] chain_q
);
    always_ff @(posedge clk) begin
        if (!reset) begin
            chain_q <= '0;
        end else if (scan_en) begin
            chain_q <= {chain_q[N-2:0], scan_in};
        end
    end

    assign scan_out = chain_q[N-1];
endmodule

// File: rtl/scan_chain_loader.sv
// rtl/scan_chain_loader.sv - serialises a layer config onto the scan chain
// Captures the displaced chain contents and optionally reads the new load back.
module scan_chain_loader
    import scan_chain_pkg::*;
#(
    parameter int CHAIN_LEN = scan_chain_pkg::CHAIN_LEN,
    parameter int CNT_WIDTH = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    scan_chain_loader_if.slave   req,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rb_data,
    output logic                 verify_ok
);
    state_t                 state;
    logic                   ready_q;
    logic [CHAIN_LEN-1:0]   tx;
    logic [CHAIN_LEN-1:0]   rx;
    logic [CHAIN_LEN-1:0]   cfg_q;
    logic                   verify_q;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CHAIN_LEN-1:0]   rx_next;

    localparam logic [CNT_WIDTH-1:0] CNT_RELOAD = CNT_WIDTH'(CHAIN_LEN - 1);

    assign req.req_ready = ready_q;
    // scan_out is captured on the same edge the chain shifts, so the last
    // captured bit must be folded in when rb_data/verify_ok are registered.
    assign rx_next = {rx[CHAIN_LEN-2:0], scan_out};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            scan_en   <= 1'b0;
            scan_in   <= 1'b0;
            done      <= 1'b0;
            rb_data   <= '0;
            verify_ok <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            cfg_q     <= '0;
            verify_q  <= 1'b0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (req.req_valid && ready_q) begin
                        state    <= LOAD;
                        ready_q  <= 1'b0;
                        cfg_q    <= req.req_cfg;
                        verify_q <= req.req_verify;
                        scan_en  <= 1'b1;
                        scan_in  <= req.req_cfg[CHAIN_LEN-1];
                        tx       <= req.req_cfg << 1;
                        cnt      <= CNT_RELOAD;
                    end
                end
                LOAD, VERIFY: begin
                    scan_in <= tx[CHAIN_LEN-1];
                    tx      <= tx << 1;
                    rx      <= rx_next;
                    cnt     <= cnt - 1'b1;
                    if (cnt == '0) begin
                        if (state == LOAD && verify_q) begin
                            state   <= VERIFY;
                            rb_data <= rx_next;
                            scan_in <= cfg_q[CHAIN_LEN-1];
                            tx      <= cfg_q << 1;
                            cnt     <= CNT_RELOAD;
                        end else begin
                            state   <= FIN;
                            scan_en <= 1'b0;
                            scan_in <= 1'b0;
                            done    <= 1'b1;
                            if (state == LOAD) begin
                                rb_data   <= rx_next;
                                verify_ok <= 1'b0;
                            end else begin
                                verify_ok <= (rx_next == cfg_q);
                            end
                        end
                    end
                end
                FIN: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scan_chain_loader.sv
// tb/tb_scan_chain_loader.sv - self-checking bench for scan_chain_loader
// Reference model tracks chain contents as whole vectors per request.
module tb_scan_chain_loader;
    import scan_chain_pkg::*;

    localparam int N = CHAIN_LEN;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         chain_reset = 1'b0;
    logic         flip = 1'b0;
    logic         scan_en;
    logic         scan_in;
    logic         chain_out;
    logic         scan_out;
    logic         done;
    logic [N-1:0] rb_data;
    logic         verify_ok;
    logic [N-1:0] chain_q;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic [N-1:0] model_chain = '0;
    realtime accept_time;

    scan_chain_loader_if #(.N(N)) req_if ();

    scan_chain_loader dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req_if),
        .scan_en   (scan_en),
        .scan_in   (scan_in),
        .scan_out  (scan_out),
        .done      (done),
        .rb_data   (rb_data),
        .verify_ok (verify_ok)
    );

    scan_chain #(.N(N)) chain (
        .clk      (clk),
        .reset    (chain_reset),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .scan_out (chain_out),
        .chain_q  (chain_q)
    );

    assign scan_out = chain_out ^ flip;

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_count <= done_count + 1;

    function automatic logic [N-1:0] rand_cfg();
        logic [95:0] tmp;
        tmp = {$urandom(), $urandom(), $urandom()};
        return tmp[N-1:0];
    endfunction

    // flip_at: 1-based shift cycle whose captured scan_out is inverted (0 = none)
    task automatic do_request(input logic [N-1:0] cfg, input logic verify, input int flip_at,
                              input logic hold, input logic [N-1:0] hold_cfg);
        int t;
        int len;
        int bad_en;
        int bad_in;
        int bad_done;
        logic [N-1:0] exp_rb;
        logic exp_ok;
        t = 0;
        while (req_if.req_ready !== 1'b1 && t < 300) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        if (req_if.req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_wait: req_ready=%b required 1", req_if.req_ready);
        end
        req_if.req_valid  = 1'b1;
        req_if.req_cfg    = cfg;
        req_if.req_verify = verify;
        @(posedge clk);
        accept_time = $realtime;
        #1;
        if (hold) begin
            req_if.req_cfg    = hold_cfg;
            req_if.req_verify = 1'b0;
        end else begin
            req_if.req_valid = 1'b0;
        end
        exp_rb = model_chain;
        exp_ok = verify && (flip_at == 0);
        len = verify ? 2 * N : N;
        bad_en = 0; bad_in = 0; bad_done = 0;
        for (int i = 1; i <= len; i++) begin
            flip = (i == flip_at);
            @(negedge clk);
            if (scan_en !== 1'b1) bad_en++;
            if (scan_in !== cfg[N - ((i - 1) % N + 1)]) bad_in++;
            if (done !== 1'b0) bad_done++;
            @(posedge clk); #1;
        end
        flip = 1'b0;
        checks += 3;
        if (bad_en != 0) begin errors++; $display("FAIL scan_en_window: %0d low cycles required 0 of %0d", bad_en, len); end
        if (bad_in != 0) begin errors++; $display("FAIL scan_in_bits: %0d wrong bits required 0", bad_in); end
        if (bad_done != 0) begin errors++; $display("FAIL early_done: %0d cycles required 0", bad_done); end
        @(negedge clk);
        checks += 6;
        if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: done=%b required 1", done); end
        if (scan_en !== 1'b0) begin errors++; $display("FAIL scan_en_end: scan_en=%b required 0", scan_en); end
        if (rb_data !== exp_rb) begin errors++; $display("FAIL rb_data: got %h required %h", rb_data, exp_rb); end
        if (verify_ok !== exp_ok) begin errors++; $display("FAIL verify_ok: got %b required %b", verify_ok, exp_ok); end
        if (req_if.req_ready !== 1'b0) begin errors++; $display("FAIL ready_in_fin: req_ready=%b required 0", req_if.req_ready); end
        if (chain_q !== cfg) begin errors++; $display("FAIL chain_contents: got %h required %h", chain_q, cfg); end
        model_chain = cfg;
        @(posedge clk); #1;
        @(negedge clk);
        checks += 3;
        if (done !== 1'b0) begin errors++; $display("FAIL done_width: done=%b required 0", done); end
        if (req_if.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after: req_ready=%b required 1", req_if.req_ready); end
        if (scan_en !== 1'b0) begin errors++; $display("FAIL scan_en_idle: scan_en=%b required 0", scan_en); end
    endtask

    task automatic test_reset();
        req_if.req_valid = 1'b0; req_if.req_cfg = '0; req_if.req_verify = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (scan_en !== 1'b0) begin errors++; $display("FAIL rst_scan_en: got %b required 0", scan_en); end
        if (scan_in !== 1'b0) begin errors++; $display("FAIL rst_scan_in: got %b required 0", scan_in); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
        if (rb_data !== '0) begin errors++; $display("FAIL rst_rb_data: got %h required 0", rb_data); end
        if (verify_ok !== 1'b0) begin errors++; $display("FAIL rst_verify_ok: got %b required 0", verify_ok); end
        if (req_if.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", req_if.req_ready); end
        chain_reset = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_if.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", req_if.req_ready); end
        model_chain = '0;
    endtask

    task automatic test_basic();
        cfg_t c;
        cfg_t got;
        c = '0; c.h = 8'hA5; c.w = 8'h3C; c.pt = 3'b101;
        do_request(c, 1'b0, 0, 1'b0, '0);
        got = chain_q;
        checks++;
        if (got.h !== 8'hA5 || got.w !== 8'h3C || got.pt !== 3'b101) begin
            errors++; $display("FAIL basic_fields: H=%h W=%h t=%h required A5 3C 5", got.h, got.w, got.pt);
        end
    endtask

    task automatic test_back_to_back();
        realtime t1;
        do_request({N{1'b1}}, 1'b0, 0, 1'b0, '0);
        t1 = accept_time;
        do_request('0, 1'b0, 0, 1'b0, '0);
        checks++;
        if ((accept_time - t1) != 940.0) begin
            errors++; $display("FAIL b2b_period: %0t required %0d cycles", accept_time - t1, N + 2);
        end
    endtask

    task automatic test_verify();
        cfg_t c;
        c = '0; c.c = 10'h2AB; c.m = 10'h155;
        do_request(c, 1'b1, 0, 1'b0, '0);
    endtask

    task automatic test_corrupt();
        do_request(rand_cfg(), 1'b1, N + 17, 1'b0, '0);
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] cfg;
        int d0;
        cfg = rand_cfg();
        d0 = done_count;
        req_if.req_valid = 1'b1; req_if.req_cfg = cfg; req_if.req_verify = 1'b0;
        @(posedge clk); #1;
        req_if.req_valid = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (scan_en !== 1'b0) begin errors++; $display("FAIL midrst_scan_en: got %b required 0", scan_en); end
        if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b required 0", done); end
        if (req_if.req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b required 0", req_if.req_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (req_if.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_release: ready=%b required 1", req_if.req_ready); end
        if (done_count != d0) begin errors++; $display("FAIL midrst_no_done: %0d pulses required 0", done_count - d0); end
        model_chain = (model_chain << 40) | (cfg >> (N - 40));
        do_request(rand_cfg(), 1'b0, 0, 1'b0, '0);
    endtask

    task automatic test_hold();
        logic [N-1:0] c1;
        logic [N-1:0] c2;
        realtime t1;
        c1 = rand_cfg();
        c2 = ~c1;
        do_request(c1, 1'b0, 0, 1'b1, c2);
        t1 = accept_time;
        do_request(c2, 1'b0, 0, 1'b0, '0);
        checks++;
        if ((accept_time - t1) != 940.0) begin
            errors++; $display("FAIL hold_accept: %0t required %0d cycles", accept_time - t1, N + 2);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            do_request(rand_cfg(), 1'($urandom_range(1)), 0, 1'b0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_verify();
        test_corrupt();
        test_mid_reset();
        test_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
